// File: rtl/button_ctrl_pkg.sv
// Shared types and helpers for the front-panel button controller.
// Holds the FSM state encoding and the button index constants.
package button_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        HOLD     = 3'd2,
        REPEAT   = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [1:0] BTN_NANO   = 2'd0;
    localparam logic [1:0] BTN_MICRO  = 2'd1;
    localparam logic [1:0] BTN_COARSE = 2'd2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Buttons are active low: exactly one zero bit is a valid single press.
    function automatic logic is_single_press(input logic [2:0] btn);
        return (btn == 3'b110) || (btn == 3'b101) || (btn == 3'b011);
    endfunction

    function automatic logic [1:0] press_index(input logic [2:0] btn);
        logic [1:0] idx;
        case (btn)
            3'b110:  idx = BTN_NANO;
            3'b101:  idx = BTN_MICRO;
            3'b011:  idx = BTN_COARSE;
            default: idx = BTN_NANO;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] btn_mask(input logic [1:0] idx);
        logic [2:0] m;
        case (idx)
            BTN_NANO:   m = 3'b001;
            BTN_MICRO:  m = 3'b010;
            BTN_COARSE: m = 3'b100;
            default:    m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Multi-bit two-flop synchroniser with a configurable reset value.
// Each bit is synchronised independently; no cross-bit coherency is implied.
module button_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_ctrl.sv
// Debounced three-button panel producing frequency, phase and PWM-duty step pulses.
//   state    | meaning
//   IDLE     | waiting for exactly one button low
//   DEBOUNCE | pattern must stay stable for DEB_CYCLES clocks
//   HOLD     | first step issued, counting towards auto-repeat
//   REPEAT   | one step every REPEAT_CYCLES clocks while held
//   RELEASE  | all buttons must stay high for DEB_CYCLES clocks
module button_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int                DEB_CYCLES    = 1_000_000,
    parameter int                HOLD_CYCLES   = 25_000_000,
    parameter int                REPEAT_CYCLES = 5_000_000,
    parameter int                DUTY_W        = 32,
    parameter logic [DUTY_W-1:0] DUTY_STEP     = {{(DUTY_W-1){1'b0}}, 1'b1} << (DUTY_W-2),
    parameter bit                DUTY_SAT      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freq_phase_sel,
    input  logic              up_down_sel,
    input  logic [2:0]        push_button,
    input  logic              duty_clr,
    output logic [2:0]        freq_step_up,
    output logic [2:0]        freq_step_dn,
    output logic              phase_up,
    output logic              phase_dn,
    output logic [DUTY_W-1:0] pwm_duty,
    output logic              busy
);

    localparam int MAX_CYC = max3(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [DUTY_W-1:0] DUTY_MID  = {1'b1, {(DUTY_W-1){1'b0}}};

    logic [4:0] sync_d;
    logic [4:0] sync_q;
    logic       sel_freq_s;
    logic       sel_up_s;
    logic [2:0] btn_s;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       btn_idx;
    logic [2:0]       btn_pat;
    logic             mode_freq;
    logic             mode_up;
    logic             latch;
    logic             step;
    logic             step_req;
    logic             all_high;
    logic             pat_same;

    logic              duty_evt;
    logic [DUTY_W:0]   duty_sum;
    logic [DUTY_W:0]   duty_dif;
    logic [DUTY_W-1:0] duty_nxt;

    // Selectors share the button synchroniser so a press and its mode are seen on the same clock.
    assign sync_d = {freq_phase_sel, up_down_sel, push_button};

    button_sync #(
        .WIDTH   (5),
        .RST_VAL (5'b11111)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sync_d),
        .q     (sync_q)
    );

    assign sel_freq_s = sync_q[4];
    assign sel_up_s   = sync_q[3];
    assign btn_s      = sync_q[2:0];

    assign all_high = &btn_s;
    assign pat_same = (btn_s == btn_pat);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_idx   <= '0;
            btn_pat   <= '0;
            mode_freq <= 1'b0;
            mode_up   <= 1'b0;
            step_req  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            step_req <= step;
            if (latch) begin
                btn_idx   <= press_index(btn_s);
                btn_pat   <= btn_s;
                mode_freq <= sel_freq_s;
                mode_up   <= sel_up_s;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (is_single_press(btn_s)) begin
                    latch     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!pat_same) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == DEB_LAST) begin
                    step      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                // Release and a second button both end the press without a further step.
                if (all_high || !pat_same) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else if (cnt == HOLD_LAST) begin
                    step      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REPEAT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (all_high || !pat_same) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else if (cnt == REP_LAST) begin
                    step    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!all_high) begin
                    cnt_nxt = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Latched mode only; step_req lags the FSM by one clock and latch cannot fire in HOLD/REPEAT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_step_up <= '0;
            freq_step_dn <= '0;
            phase_up     <= 1'b0;
            phase_dn     <= 1'b0;
        end else begin
            freq_step_up <= '0;
            freq_step_dn <= '0;
            phase_up     <= 1'b0;
            phase_dn     <= 1'b0;
            if (step_req && mode_freq) begin
                if (mode_up) begin
                    freq_step_up <= btn_mask(btn_idx);
                end else begin
                    freq_step_dn <= btn_mask(btn_idx);
                end
            end else if (step_req && (btn_idx == BTN_MICRO)) begin
                phase_up <= mode_up;
                phase_dn <= !mode_up;
            end
        end
    end

    assign duty_evt = step_req && !mode_freq && (btn_idx == BTN_NANO);

    always_comb begin
        duty_sum = {1'b0, pwm_duty} + {1'b0, DUTY_STEP};
        duty_dif = {1'b0, pwm_duty} - {1'b0, DUTY_STEP};
        duty_nxt = pwm_duty;
        if (mode_up) begin
            duty_nxt = (DUTY_SAT && duty_sum[DUTY_W]) ? {DUTY_W{1'b1}} : duty_sum[DUTY_W-1:0];
        end else begin
            duty_nxt = (DUTY_SAT && duty_dif[DUTY_W]) ? {DUTY_W{1'b0}} : duty_dif[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_duty <= DUTY_MID;
        end else if (duty_clr) begin
            pwm_duty <= DUTY_MID;
        end else if (duty_evt) begin
            pwm_duty <= duty_nxt;
        end
    end

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: directed scenarios plus random presses against a timing-rule model.
// Two instances share stimulus, one with saturating duty and one with wrapping duty.
module tb_button_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int STEP = 64;
    localparam int MID  = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic       freq_phase_sel;
    logic       up_down_sel;
    logic       duty_clr;
    logic [2:0] push_button;

    logic [2:0] fu_s, fd_s, fu_w, fd_w;
    logic       pu_s, pd_s, pu_w, pd_w;
    logic       busy_s, busy_w;
    logic [7:0] duty_s, duty_w;

    int checks   = 0;
    int errors   = 0;
    int exp_sat  = MID;
    int exp_wrap = MID;

    always #5 clk = ~clk;

    button_ctrl #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
        .DUTY_W(8), .DUTY_STEP(8'd64), .DUTY_SAT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .freq_phase_sel(freq_phase_sel), .up_down_sel(up_down_sel),
        .push_button(push_button), .duty_clr(duty_clr),
        .freq_step_up(fu_s), .freq_step_dn(fd_s), .phase_up(pu_s), .phase_dn(pd_s),
        .pwm_duty(duty_s), .busy(busy_s)
    );

    button_ctrl #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
        .DUTY_W(8), .DUTY_STEP(8'd64), .DUTY_SAT(1'b0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .freq_phase_sel(freq_phase_sel), .up_down_sel(up_down_sel),
        .push_button(push_button), .duty_clr(duty_clr),
        .freq_step_up(fu_w), .freq_step_dn(fd_w), .phase_up(pu_w), .phase_dn(pd_w),
        .pwm_duty(duty_w), .busy(busy_w)
    );

    // A press held low for samples 0..len-1 steps at 3+DEB, then +HOLD, then every REP,
    // each step needing the button still low at the sample three clocks before the pulse.
    function automatic bit step_due(input int k, input int len);
        int first;
        int second;
        first  = 3 + DEB;
        second = first + HOLD;
        if (k - 3 > len - 1) return 1'b0;
        if (k == first || k == second) return 1'b1;
        return (k > second) && (((k - second) % REP) == 0);
    endfunction

    function automatic int duty_up(input int d, input bit sat);
        int s;
        s = d + STEP;
        if (sat) return (s > 255) ? 255 : s;
        return s % 256;
    endfunction

    function automatic int duty_dn(input int d, input bit sat);
        int s;
        s = d - STEP;
        if (sat) return (s < 0) ? 0 : s;
        return (s + 256) % 256;
    endfunction

    task automatic set_sel(input bit fsel, input bit ud);
        @(negedge clk);
        freq_phase_sel = fsel;
        up_down_sel    = ud;
        push_button    = 3'b111;
        duty_clr       = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic run_press(input int btn, input bit fsel, input bit ud, input int len,
                             input int gap, input int clr_at, input bit scramble);
        logic [2:0] mask;
        logic [7:0] exp_p;
        bit         due;
        mask = 3'b001 << btn;
        for (int k = 0; k < len + gap; k++) begin
            @(negedge clk);
            push_button = (k < len) ? ~mask : 3'b111;
            duty_clr    = (k == clr_at);
            if (scramble && k >= 1) begin
                freq_phase_sel = 1'($urandom_range(0, 1));
                up_down_sel    = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            due   = step_due(k, len);
            exp_p = {(due && fsel && ud) ? mask : 3'b000,
                     (due && fsel && !ud) ? mask : 3'b000,
                     due && !fsel && (btn == 1) && ud,
                     due && !fsel && (btn == 1) && !ud};
            if (k == clr_at) begin
                exp_sat  = MID;
                exp_wrap = MID;
            end else if (due && !fsel && (btn == 0)) begin
                exp_sat  = ud ? duty_up(exp_sat, 1'b1)  : duty_dn(exp_sat, 1'b1);
                exp_wrap = ud ? duty_up(exp_wrap, 1'b0) : duty_dn(exp_wrap, 1'b0);
            end
            checks++;
            if ({fu_s, fd_s, pu_s, pd_s, fu_w, fd_w, pu_w, pd_w} !== {exp_p, exp_p}) begin
                errors++;
                $display("FAIL press_pulses btn=%0d k=%0d: got %b/%b required %b", btn, k,
                         {fu_s, fd_s, pu_s, pd_s}, {fu_w, fd_w, pu_w, pd_w}, exp_p);
            end
            checks++;
            if (duty_s !== 8'(exp_sat)) begin
                errors++;
                $display("FAIL duty_sat k=%0d: got %0d required %0d", k, duty_s, exp_sat);
            end
            checks++;
            if (duty_w !== 8'(exp_wrap)) begin
                errors++;
                $display("FAIL duty_wrap k=%0d: got %0d required %0d", k, duty_w, exp_wrap);
            end
            if (k == 2) begin
                checks++;
                if ({busy_s, busy_w} !== 2'b11) begin
                    errors++;
                    $display("FAIL busy_press k=%0d: got %b required 11", k, {busy_s, busy_w});
                end
            end
            if (k == len + gap - 1) begin
                checks++;
                if ({busy_s, busy_w} !== 2'b00) begin
                    errors++;
                    $display("FAIL busy_idle k=%0d: got %b required 00", k, {busy_s, busy_w});
                end
            end
        end
        duty_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        push_button    = 3'b110;
        freq_phase_sel = 1'b1;
        up_down_sel    = 1'b1;
        duty_clr       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_s, busy_w} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy: got %b required 00", {busy_s, busy_w});
        end
        checks++;
        if ({fu_s, fd_s, pu_s, pd_s, fu_w, fd_w, pu_w, pd_w} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b required 0", {fu_s, fd_s, pu_s, pd_s});
        end
        checks++;
        if (duty_s !== 8'd128 || duty_w !== 8'd128) begin
            errors++;
            $display("FAIL reset_duty: got %0d/%0d required 128", duty_s, duty_w);
        end
        @(negedge clk);
        push_button = 3'b111;
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_s, busy_w} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_busy: got %b required 00", {busy_s, busy_w});
        end
    endtask

    task automatic test_single_press();
        set_sel(1'b1, 1'b1);
        run_press(0, 1'b1, 1'b1, 8, 12, -1, 1'b0);
    endtask

    task automatic test_bounce();
        bit low;
        bit due;
        int pulses = 0;
        set_sel(1'b1, 1'b1);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            low = (k < 15) ? ((k % 3) != 2) : (k < 21);
            push_button = low ? 3'b101 : 3'b111;
            @(posedge clk);
            #1;
            due = (k == 15 + 3 + DEB);
            if (fu_s[1]) pulses++;
            checks++;
            if ({fu_s, fd_s, pu_s, pd_s} !== {(due ? 3'b010 : 3'b000), 5'b00000}) begin
                errors++;
                $display("FAIL bounce_pulses k=%0d: got %b required step=%0d", k,
                         {fu_s, fd_s, pu_s, pd_s}, due);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d required 1", pulses);
        end
    endtask

    task automatic test_repeat();
        set_sel(1'b1, 1'b0);
        run_press(2, 1'b1, 1'b0, 28, 12, -1, 1'b0);
    endtask

    task automatic test_duty();
        set_sel(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run_press(0, 1'b0, 1'b1, 6, 12, -1, 1'b0);
        checks++;
        if (duty_s !== 8'd255 || duty_w !== 8'd64) begin
            errors++;
            $display("FAIL duty_after_ups: got %0d/%0d required 255/64", duty_s, duty_w);
        end
        set_sel(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) run_press(0, 1'b0, 1'b0, 6, 12, -1, 1'b0);
        checks++;
        if (duty_s !== 8'd0 || duty_w !== 8'd0) begin
            errors++;
            $display("FAIL duty_after_downs: got %0d/%0d required 0/0", duty_s, duty_w);
        end
        set_sel(1'b0, 1'b1);
        run_press(0, 1'b0, 1'b1, 6, 12, 7, 1'b0);
        checks++;
        if (duty_s !== 8'd128 || duty_w !== 8'd128) begin
            errors++;
            $display("FAIL duty_clr_wins: got %0d/%0d required 128", duty_s, duty_w);
        end
        run_press(0, 1'b0, 1'b1, 6, 12, -1, 1'b0);
    endtask

    task automatic test_phase();
        set_sel(1'b0, 1'b1);
        run_press(1, 1'b0, 1'b1, 6, 12, -1, 1'b0);
        set_sel(1'b0, 1'b0);
        run_press(1, 1'b0, 1'b0, 20, 12, -1, 1'b0);
        run_press(2, 1'b0, 1'b0, 20, 12, -1, 1'b0);
    endtask

    task automatic test_multi_button();
        set_sel(1'b1, 1'b1);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            push_button = 3'b100;
            @(posedge clk);
            #1;
            checks++;
            if ({fu_s, fd_s, pu_s, pd_s, busy_s} !== 9'b0) begin
                errors++;
                $display("FAIL multi_button k=%0d: got %b required 0", k, {fu_s, fd_s, pu_s, pd_s, busy_s});
            end
        end
        @(negedge clk);
        push_button = 3'b111;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_second_button();
        bit due;
        set_sel(1'b1, 1'b1);
        for (int k = 0; k < 39; k++) begin
            @(negedge clk);
            push_button = (k < 8) ? 3'b110 : ((k < 25) ? 3'b100 : 3'b111);
            @(posedge clk);
            #1;
            due = (k == 3 + DEB);
            checks++;
            if ({fu_s, fd_s, pu_s, pd_s} !== {(due ? 3'b001 : 3'b000), 5'b00000}) begin
                errors++;
                $display("FAIL second_button k=%0d: got %b required step=%0d", k,
                         {fu_s, fd_s, pu_s, pd_s}, due);
            end
            if (k == 20 || k == 38) begin
                checks++;
                if (busy_s !== (k == 20)) begin
                    errors++;
                    $display("FAIL second_button_busy k=%0d: got %b required %b", k, busy_s, k == 20);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        set_sel(1'b1, 1'b1);
        @(negedge clk);
        push_button = 3'b011;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL midpress_busy: got %b required 1", busy_s);
        end
        reset = 1'b1;
        #1;
        exp_sat  = MID;
        exp_wrap = MID;
        checks++;
        if ({busy_s, busy_w} !== 2'b00 || duty_s !== 8'd128 || duty_w !== 8'd128) begin
            errors++;
            $display("FAIL midpress_reset: got busy=%b duty=%0d/%0d required busy=00 duty=128",
                     {busy_s, busy_w}, duty_s, duty_w);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({fu_s, fd_s, pu_s, pd_s, busy_s} !== 9'b0) begin
                errors++;
                $display("FAIL midpress_abort k=%0d: got %b required 0", k, {fu_s, fd_s, pu_s, pd_s, busy_s});
            end
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_press(2, 1'b1, 1'b1, 8, 12, -1, 1'b0);
    endtask

    task automatic test_random();
        int btn, len, gap, clr_at;
        bit fsel, ud;
        for (int n = 0; n < 14; n++) begin
            btn    = $urandom_range(0, 2);
            fsel   = 1'($urandom_range(0, 1));
            ud     = 1'($urandom_range(0, 1));
            len    = $urandom_range(1, 30);
            gap    = $urandom_range(10, 14);
            clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + gap - 1) : -1;
            set_sel(fsel, ud);
            run_press(btn, fsel, ud, len, gap, clr_at, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_duty();
        test_phase();
        test_multi_button();
        test_second_button();
        test_reset_mid_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
